// File: rtl/quad_encoder_pkg.sv
// Shared definitions for the quadrature encoder decoder.
//   ADDR_STATUS / ADDR_ID : fixed register word addresses
//   ID_VALUE              : ID register base, OR'ed with the channel count
//   step_t / decode_step  : classification of one sampled (A,B) transition
package quad_encoder_pkg;

  localparam logic [3:0]  ADDR_STATUS = 4'd8;
  localparam logic [3:0]  ADDR_ID     = 4'd9;
  localparam logic [31:0] ID_VALUE    = 32'h51E0_0000;

  typedef enum logic [1:0] {STEP_NONE, STEP_INC, STEP_DEC, STEP_ERR} step_t;

  // Pin pairs are packed {A,B}. Forward rotation is 00->10->11->01->00.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if (prev == cur) begin
      s = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      s = STEP_ERR;
    end else begin
      case ({prev, cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: s = STEP_INC;
        default:                                s = STEP_DEC;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/quad_encoder_if.sv
// Avalon-MM register port of the quadrature encoder decoder.
//   iAVL_ADDRESS / iAVL_READ / iAVL_WRITE / iAVL_WRITE_DATA : master -> slave
//   oAVL_READ_DATA / oAVL_READ_DATAVALID                    : slave -> master
// Handshake: there is no waitrequest, so a read or write strobe is accepted on
// every clock edge where it is high. Read data is registered and returned on
// the following cycle with oAVL_READ_DATAVALID high for exactly that cycle;
// oAVL_READ_DATA then holds until the next read.
interface quad_encoder_if;
  logic [3:0]  iAVL_ADDRESS;
  logic        iAVL_READ;
  logic        iAVL_WRITE;
  logic [31:0] iAVL_WRITE_DATA;
  logic [31:0] oAVL_READ_DATA;
  logic        oAVL_READ_DATAVALID;

  modport master (
    output iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA,
    input  oAVL_READ_DATA, oAVL_READ_DATAVALID
  );

  modport slave (
    input  iAVL_ADDRESS, iAVL_READ, iAVL_WRITE, iAVL_WRITE_DATA,
    output oAVL_READ_DATA, oAVL_READ_DATAVALID
  );
endinterface

// File: rtl/quad_encoder_channel.sv
// One quadrature channel: 2-flop synchroniser, history, primed flag,
// wrap-around position counter and sticky error flag.
//   clk_i, rst_n_i : clock, async active-low reset
//   enc_a_i/enc_b_i: raw asynchronous pins
//   tick_i         : sample strobe shared by all channels
//   load_i/load_data_i : register write of the count (wins over a step)
//   clr_err_i      : W1C of the error flag (loses to a new error)
//   count_o, err_o : current count and sticky error
//   step_o         : decoded step of this cycle (debug visibility)
module quad_encoder_channel
  import quad_encoder_pkg::*;
#(
  parameter int pCOUNT_BITS = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enc_a_i,
  input  logic                   enc_b_i,
  input  logic                   tick_i,
  input  logic                   load_i,
  input  logic [pCOUNT_BITS-1:0] load_data_i,
  input  logic                   clr_err_i,
  output logic [pCOUNT_BITS-1:0] count_o,
  output logic                   err_o,
  output step_t                  step_o
);

  localparam logic [pCOUNT_BITS-1:0] ONE = pCOUNT_BITS'(1);

  logic [1:0]             sync1_q, sync2_q;
  logic [1:0]             hist_q, hist_d;
  logic                   primed_q, primed_d;
  logic [pCOUNT_BITS-1:0] count_q, count_d;
  logic                   err_q, err_d;
  step_t                  step;

  always_comb begin
    step = STEP_NONE;
    // The priming tick only captures history so reset values never decode.
    if (tick_i && primed_q) step = decode_step(hist_q, sync2_q);

    hist_d   = tick_i ? sync2_q : hist_q;
    primed_d = primed_q | tick_i;

    count_d = count_q;
    case (step)
      STEP_INC: count_d = count_q + ONE;
      STEP_DEC: count_d = count_q - ONE;
      default:  count_d = count_q;
    endcase
    if (load_i) count_d = load_data_i;

    err_d = (err_q & ~clr_err_i) | (step == STEP_ERR);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      hist_q   <= 2'b00;
      primed_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      sync1_q  <= {enc_a_i, enc_b_i};
      sync2_q  <= sync1_q;
      hist_q   <= hist_d;
      primed_q <= primed_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign count_o = count_q;
  assign err_o   = err_q;
  assign step_o  = step;

endmodule

// File: rtl/quad_encoder.sv
// Multi-channel x4 quadrature decoder with an Avalon-MM register slave.
//   iCLK, iRESETn  : clock, async active-low reset
//   iENC_A, iENC_B : asynchronous encoder pins, one bit per channel
//   avl            : register port (see quad_encoder_if)
// Registers: 0..7 counts (load on write), 8 error flags (W1C), 9 ID.
module quad_encoder
  import quad_encoder_pkg::*;
#(
  parameter int pENCODERS       = 2,
  parameter int pCOUNT_BITS     = 16,
  parameter int pPRESCALER_BITS = 6
) (
  input  logic                 iCLK,
  input  logic                 iRESETn,
  input  logic [pENCODERS-1:0] iENC_A,
  input  logic [pENCODERS-1:0] iENC_B,
  quad_encoder_if.slave        avl
);

  localparam logic [pPRESCALER_BITS-1:0] PS_ONE = pPRESCALER_BITS'(1);

  logic [pPRESCALER_BITS-1:0] prescaler_q;
  logic                       warm_q, warm_d;
  logic                       tick_raw, tick;
  logic [31:0]                rdata_q, rdata_d;
  logic                       rvalid_q;

  logic [pCOUNT_BITS-1:0] cnt [pENCODERS];
  logic [pENCODERS-1:0]   err;
  logic [pENCODERS-1:0]   load;
  logic [pENCODERS-1:0]   clr_err;
  step_t                  step_dbg [pENCODERS];

  // The very first prescaler wrap after reset arrives before the
  // synchronisers hold real pin values, so it is swallowed; the next tick is
  // the priming tick and sees the true pin state.
  assign tick_raw = (prescaler_q == '0);
  assign tick     = tick_raw & warm_q;
  assign warm_d   = warm_q | tick_raw;

  for (genvar g = 0; g < pENCODERS; g++) begin : g_ch
    assign load[g]    = avl.iAVL_WRITE && (avl.iAVL_ADDRESS == 4'(g));
    assign clr_err[g] = avl.iAVL_WRITE && (avl.iAVL_ADDRESS == ADDR_STATUS)
                        && avl.iAVL_WRITE_DATA[g];

    quad_encoder_channel #(.pCOUNT_BITS(pCOUNT_BITS)) u_ch (
      .clk_i       (iCLK),
      .rst_n_i     (iRESETn),
      .enc_a_i     (iENC_A[g]),
      .enc_b_i     (iENC_B[g]),
      .tick_i      (tick),
      .load_i      (load[g]),
      .load_data_i (avl.iAVL_WRITE_DATA[pCOUNT_BITS-1:0]),
      .clr_err_i   (clr_err[g]),
      .count_o     (cnt[g]),
      .err_o       (err[g]),
      .step_o      (step_dbg[g])
    );
  end

  // Read mux samples pre-write register values, so a same-cycle read and
  // write returns the old contents.
  always_comb begin
    rdata_d = rdata_q;
    if (avl.iAVL_READ) begin
      rdata_d = '0;
      for (int i = 0; i < pENCODERS; i++) begin
        if (avl.iAVL_ADDRESS == 4'(i)) rdata_d = 32'(cnt[i]);
      end
      if (avl.iAVL_ADDRESS == ADDR_STATUS) rdata_d = 32'(err);
      if (avl.iAVL_ADDRESS == ADDR_ID)     rdata_d = ID_VALUE | 32'(pENCODERS);
    end
  end

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      prescaler_q <= '0;
      warm_q      <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      prescaler_q <= prescaler_q + PS_ONE;
      warm_q      <= warm_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= avl.iAVL_READ;
    end
  end

  assign avl.oAVL_READ_DATA      = rdata_q;
  assign avl.oAVL_READ_DATAVALID = rvalid_q;

  // Upper write-data bits beyond the count/flag width carry no meaning.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avl.iAVL_WRITE_DATA, step_dbg[0]};

endmodule

// File: tb/tb_quad_encoder.sv
module tb_quad_encoder;

  localparam int NE = 2;
  localparam int CB = 16;
  localparam int PB = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NE-1:0] enc_a = '0;
  logic [NE-1:0] enc_b = '0;

  quad_encoder_if avl();

  quad_encoder #(.pENCODERS(NE), .pCOUNT_BITS(CB), .pPRESCALER_BITS(PB)) dut (
    .iCLK    (clk),
    .iRESETn (rst_n),
    .iENC_A  (enc_a),
    .iENC_B  (enc_b),
    .avl     (avl)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  // Edges since reset release; edge k sees prescaler value (k-1) mod 4.
  int edge_n;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  // ---------------- reference model ----------------
  // Position is tracked as a phase 0..3 around the Gray cycle; the signed
  // phase difference of a transition tells the step.
  int            m_cnt [NE];
  logic [NE-1:0] m_err;
  int            pin_ph [NE];

  int checks = 0;
  int errors = 0;

  function automatic logic [1:0] ph2ab(input int ph);
    case (ph)
      0: return 2'b00;
      1: return 2'b10;
      2: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NE; i++) m_cnt[i] = 0;
    m_err = '0;
  endfunction

  function automatic void model_write(input logic [3:0] addr, input logic [31:0] data);
    if (addr < NE)       m_cnt[addr] = int'(data[CB-1:0]);
    else if (addr == 8)  m_err = m_err & ~data[NE-1:0];
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    if (addr < NE)  return 32'(m_cnt[addr]);
    if (addr == 8)  return 32'(m_err);
    if (addr == 9)  return 32'h51E0_0002;
    return 32'h0;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered and left on a negedge) ----------------
  task automatic rd(input string tag, input logic [3:0] addr);
    logic [31:0] exp;
    exp = model_read(addr);
    avl.iAVL_ADDRESS = addr;
    avl.iAVL_READ    = 1'b1;
    @(negedge clk);
    avl.iAVL_READ    = 1'b0;
    check({tag, "_dv"}, 32'(avl.oAVL_READ_DATAVALID), 32'h1);
    check(tag, avl.oAVL_READ_DATA, exp);
    @(negedge clk);
    check({tag, "_dv_off"}, 32'(avl.oAVL_READ_DATAVALID), 32'h0);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    avl.iAVL_ADDRESS    = addr;
    avl.iAVL_WRITE_DATA = data;
    avl.iAVL_WRITE      = 1'b1;
    @(negedge clk);
    avl.iAVL_WRITE      = 1'b0;
    model_write(addr, data);
  endtask

  task automatic drive_pins(input int ch, input int ph);
    logic [1:0] ab;
    ab = ph2ab(ph);
    pin_ph[ch] = ph;
    enc_a[ch]  = ab[1];
    enc_b[ch]  = ab[0];
  endtask

  // Move a channel by d phases (1 fwd, 3 back, 2 = illegal jump, 0 = none).
  // Pins change so the decode lands on a known edge; an optional register
  // write is placed on exactly that edge. Pins then stay put 8+ clocks.
  task automatic step(input int ch, input int d, input bit do_wr,
                      input logic [3:0] waddr, input logic [31:0] wdata);
    logic [NE-1:0] set;
    while ((edge_n % 4) != 2 || edge_n < 10) @(negedge clk);
    drive_pins(ch, (pin_ph[ch] + d) % 4);
    @(negedge clk);
    @(negedge clk);
    if (do_wr) begin
      avl.iAVL_ADDRESS    = waddr;
      avl.iAVL_WRITE_DATA = wdata;
      avl.iAVL_WRITE      = 1'b1;
    end
    @(negedge clk);
    avl.iAVL_WRITE = 1'b0;
    set = '0;
    case (d)
      1: m_cnt[ch] = (m_cnt[ch] + 1) & 'hFFFF;
      3: m_cnt[ch] = (m_cnt[ch] + 'hFFFF) & 'hFFFF;
      2: set[ch] = 1'b1;
      default: ;
    endcase
    if (do_wr) model_write(waddr, wdata);
    m_err = m_err | set;
    repeat (5) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_rdata", avl.oAVL_READ_DATA, 32'h0);
    check("rst_dv", 32'(avl.oAVL_READ_DATAVALID), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] old_val;
    avl.iAVL_ADDRESS    = '0;
    avl.iAVL_READ       = 1'b0;
    avl.iAVL_WRITE      = 1'b0;
    avl.iAVL_WRITE_DATA = '0;
    for (int i = 0; i < NE; i++) pin_ph[i] = 0;
    model_reset();

    repeat (2) @(negedge clk);
    pulse_reset();

    // four forward steps on ch0
    for (int i = 0; i < 4; i++) step(0, 1, 1'b0, 4'd0, 32'h0);
    rd("fwd4_c0", 4'd0);
    rd("fwd4_c1", 4'd1);
    rd("fwd4_err", 4'd8);

    // reverse from zero wraps, then back to zero
    step(1, 3, 1'b0, 4'd0, 32'h0);
    rd("rev_wrap_c1", 4'd1);
    step(1, 1, 1'b0, 4'd0, 32'h0);
    rd("rev_back_c1", 4'd1);

    // illegal jump 00->11, W1C, then W1C colliding with a new error
    step(0, 2, 1'b0, 4'd0, 32'h0);
    rd("jump_err", 4'd8);
    rd("jump_cnt", 4'd0);
    wr(4'd8, 32'h1);
    rd("w1c_err", 4'd8);
    step(0, 2, 1'b1, 4'd8, 32'h1);
    rd("w1c_vs_set", 4'd8);
    wr(4'd8, 32'h3);
    rd("w1c_again", 4'd8);

    // load collides with a decoded step: load wins
    step(0, 1, 1'b1, 4'd0, 32'h0000_1234);
    rd("load_wins", 4'd0);
    step(0, 1, 1'b0, 4'd0, 32'h0);
    rd("load_then_step", 4'd0);

    // same-cycle read and write returns the old value
    old_val = model_read(4'd0);
    avl.iAVL_ADDRESS    = 4'd0;
    avl.iAVL_WRITE_DATA = 32'hCAFE_BEEF;
    avl.iAVL_READ       = 1'b1;
    avl.iAVL_WRITE      = 1'b1;
    @(negedge clk);
    avl.iAVL_READ  = 1'b0;
    avl.iAVL_WRITE = 1'b0;
    check("rw_same_cycle", avl.oAVL_READ_DATA, old_val);
    model_write(4'd0, 32'hCAFE_BEEF);
    @(negedge clk);
    rd("rw_after", 4'd0);

    // ignored writes and constant registers
    wr(4'd12, 32'hFFFF_FFFF);
    wr(4'd5, 32'h0000_AAAA);
    rd("ign_c0", 4'd0);
    rd("ign_c1", 4'd1);
    rd("addr5", 4'd5);
    rd("addr12", 4'd12);
    rd("id", 4'd9);

    // pins held at 11 through reset release
    rst_n = 1'b0;
    model_reset();
    drive_pins(0, 2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    while (edge_n < 10) @(negedge clk);
    rd("prime_c0", 4'd0);
    rd("prime_err", 4'd8);
    step(0, 1, 1'b0, 4'd0, 32'h0);
    rd("prime_step", 4'd0);
    rd("prime_step_err", 4'd8);

    // randomized walk on both channels with occasional colliding writes
    for (int it = 0; it < 40; it++) begin
      int ch, d;
      bit do_wr;
      logic [3:0] wa;
      ch    = $urandom_range(0, NE - 1);
      d     = $urandom_range(0, 3);
      do_wr = ($urandom_range(0, 3) == 0);
      wa    = 4'($urandom_range(0, 9));
      step(ch, d, do_wr, wa, $urandom);
      rd("rnd_c0", 4'd0);
      rd("rnd_c1", 4'd1);
      rd("rnd_err", 4'd8);
    end

    // reset mid-sequence clears everything
    pulse_reset();
    rd("mid_rst_c0", 4'd0);
    rd("mid_rst_c1", 4'd1);
    rd("mid_rst_err", 4'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
